muldiv_unit: RTL and testbench

- Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
- Consumes the two register-bank read operands in EX (MULT, MULTU, DIV, DIVU) and sources HI/LO for MFHI/MFLO.
- Accepts MTHI/MTLO writes.
- Exposes busy/done so the pipeline controller can stall dependent instructions.

---
 rtl/muldiv_unit.sv | 154 +++++++++++++++
 tb/tb_muldiv_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// MIPS multiply/divide unit with architectural HI/LO: iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle multiplier instead of iterating.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               fix_phase;
    logic               is_div;
    logic               div_zero;
    logic               neg_res;
    logic               neg_rem;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   raw_a;
    logic [2*WIDTH-1:0] acc;

    // op[0] set means unsigned, so sign bits only matter for MULT/DIV
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    assign a_neg = ~op[0] & src_a[WIDTH-1];
    assign b_neg = ~op[0] & src_b[WIDTH-1];
    assign abs_a = a_neg ? -src_a : src_a;
    assign abs_b = b_neg ? -src_b : src_b;

    // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, quotient}
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    logic [2*WIDTH-1:0] fixed;
    always_comb begin
        fixed = acc;
        if (is_div) begin
            if (div_zero) begin
                fixed = {raw_a, {WIDTH{1'b1}}};
            end else begin
                fixed[2*WIDTH-1:WIDTH] = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                fixed[WIDTH-1:0]       = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            fixed = neg_res ? -prod : prod;
`else
            fixed = neg_res ? -acc : acc;
`endif
        end
    end

    // FIX takes two cycles: sign correction is registered before HI/LO are committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fix_phase <= 1'b0;
            is_div    <= 1'b0;
            div_zero  <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            raw_a     <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a     <= abs_a;
                        mag_b     <= abs_b;
                        raw_a     <= src_a;
                        is_div    <= op[1];
                        div_zero  <= op[1] & (src_b == '0);
                        neg_res   <= a_neg ^ b_neg;
                        neg_rem   <= a_neg;
                        acc       <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        cnt       <= '0;
                        fix_phase <= 1'b0;
                        busy      <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        state     <= op[1] ? CALC : FIX;
`else
                        state     <= CALC;
`endif
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    if (!fix_phase) begin
                        acc       <= fixed;
                        fix_phase <= 1'b1;
                    end else begin
                        hi        <= acc[2*WIDTH-1:WIDTH];
                        lo        <= acc[WIDTH-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fix_phase <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a negedge monitor checks each done pulse.
// Expected values come from 64-bit arithmetic in ref_result; MULDIV_FAST_MUL_EN changes multiply latency.
module tb_muldiv_unit;

    localparam int WIDTH    = 32;
    localparam int DIV_LAT  = WIDTH + 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
`else
    localparam int MUL_LAT  = WIDTH + 2;
`endif
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] arch_hi = '0;
    logic [31:0] arch_lo = '0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Architectural result {hi, lo} computed with plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sbv;
        longint q;
        longint r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        res = '0;
        case (o)
            OP_MULT:  res = 64'(sa * sbv);
            OP_MULTU: res = {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sbv;
                    r   = sa % sbv;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Called at a negedge; returns at the negedge after the start edge
    task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic with_mt);
        logic [63:0] r;
        exp_t        e;
        int          w;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        w = 0;
        while (busy !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (busy !== 1'b0) check_output("idle_wait", 64'(busy), 64'd0);
        old_hi = hi;
        old_lo = lo;
        op     = o;
        src_a  = a;
        src_b  = b;
        start  = 1'b1;
        hi_we  = with_mt;
        lo_we  = with_mt;
        wdata  = $urandom;
        r      = ref_result(o, a, b);
        e.hi        = r[63:32];
        e.lo        = r[31:0];
        e.start_cyc = cyc + 1;
        e.lat       = o[1] ? DIV_LAT : MUL_LAT;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        op    = 2'($urandom);
        check_output("hold_hi_after_start", 64'(hi), 64'(old_hi));
        check_output("hold_lo_after_start", 64'(lo), 64'(old_lo));
        arch_hi = e.hi;
        arch_lo = e.lo;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("result_hi", 64'(hi), 64'(mon_e.hi));
                    check_output("result_lo", 64'(lo), 64'(mon_e.lo));
                    check_output("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
                    check_output("busy_at_done", 64'(busy), 64'd0);
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].start_cyc) begin
                check_output("busy_in_flight", 64'(busy), 64'd1);
                if (cyc - exp_q[0].start_cyc > DIV_LAT + 4) begin
                    check_output("done_timeout", 64'(cyc - exp_q[0].start_cyc), 64'(exp_q[0].lat));
                    mon_e = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        #500000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] v;
        int          w;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_hi", 64'(hi), 64'd0);
        check_output("reset_lo", 64'(lo), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        apply_stimulus(OP_MULT,  32'hFFFF_FFF9, 32'd3, 1'b0);
        apply_stimulus(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);
        apply_stimulus(OP_DIVU,  32'd100, 32'd7, 1'b0);
        apply_stimulus(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        apply_stimulus(OP_DIVU,  32'd5, 32'd0, 1'b0);
        apply_stimulus(OP_DIV,   32'hFFFF_FFFB, 32'd0, 1'b0);
        apply_stimulus(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);

        // MTHI/MTLO in IDLE, both and then one at a time
        w = 0;
        while (busy !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_output("mt_both_hi", 64'(hi), 64'h1234_5678);
        check_output("mt_both_lo", 64'(lo), 64'h1234_5678);
        v     = $urandom;
        hi_we = 1'b1;
        wdata = v;
        @(negedge clk);
        hi_we = 1'b0;
        check_output("mthi_only_hi", 64'(hi), 64'(v));
        check_output("mthi_only_lo", 64'(lo), 64'h1234_5678);
        arch_hi = v;
        arch_lo = 32'h1234_5678;

        // Start and MTHI while busy must both be dropped
        apply_stimulus(OP_DIVU, 32'd9, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        start = 1'b1;
        op    = OP_MULTU;
        src_a = 32'd5;
        src_b = 32'd6;
        @(negedge clk);
        hi_we = 1'b0;
        start = 1'b0;
        check_output("busy_mthi_dropped", 64'(hi), 64'(v));

        // Start with a simultaneous MT write: start wins
        apply_stimulus(OP_MULTU, 32'd11, 32'd13, 1'b1);

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            apply_stimulus(o, a, b, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-operation aborts it
        apply_stimulus(OP_MULT, 32'd3, 32'd4, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        arch_hi = '0;
        arch_lo = '0;
        #1;
        check_output("abort_hi", 64'(hi), 64'd0);
        check_output("abort_lo", 64'(lo), 64'd0);
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_output("post_abort_hi", 64'(hi), 64'd0);
        check_output("post_abort_lo", 64'(lo), 64'd0);
        apply_stimulus(OP_MULT, 32'd3, 32'd4, 1'b0);

        w = 0;
        while (exp_q.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() > 0) check_output("drain", 64'(exp_q.size()), 64'd0);
        check_output("final_hi", 64'(hi), 64'(arch_hi));
        check_output("final_lo", 64'(lo), 64'(arch_lo));
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
